// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: handshake, decoder-flag and datapath-control bundle around the multicycle controller
interface mc_ctrl_if;
  logic imem_ack, dmem_ack, md_busy, zero;
  logic is_jr, is_j, is_jal, is_beq, is_bne, is_load, is_store, is_muldiv, writes_reg;
  logic imem_req, ir_load, pc_load, dmem_req, dmem_we, mdr_load, md_start, regfile_we, retire, bus_err;
  logic [1:0] pc_sel;
  logic [2:0] state_o;
  modport master (
    input  imem_ack, dmem_ack, md_busy, zero,
    input  is_jr, is_j, is_jal, is_beq, is_bne, is_load, is_store, is_muldiv, writes_reg,
    output imem_req, ir_load, pc_load, pc_sel, dmem_req, dmem_we, mdr_load, md_start,
    output regfile_we, retire, bus_err, state_o
  );
  modport slave (
    output imem_ack, dmem_ack, md_busy, zero,
    output is_jr, is_j, is_jal, is_beq, is_bne, is_load, is_store, is_muldiv, writes_reg,
    input  imem_req, ir_load, pc_load, pc_sel, dmem_req, dmem_we, mdr_load, md_start,
    input  regfile_we, retire, bus_err, state_o
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM with memory/mul-div handshakes and timeout traps
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int MD_TIMEOUT  = 64,
  parameter int CNT_W       = 7,
  parameter bit TRAP_EN     = 1'b1
) (
  input logic clk,
  input logic rst,
  mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, MULDIV = 3'd4, WB = 3'd5, TRAP = 3'd7
  } state_t;
  localparam logic [CNT_W-1:0] MEM_LIM = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MD_LIM  = CNT_W'(MD_TIMEOUT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic bus_err_q, on, waiting, mem_to, md_to, md_done, br_taken;
  assign on       = !rst;
  assign waiting  = state inside {FETCH, MEM, MULDIV};
  assign mem_to   = TRAP_EN && cnt == MEM_LIM;
  assign md_to    = TRAP_EN && cnt == MD_LIM && bus.md_busy;
  // md_busy is only meaningful once the unit has seen md_start, hence cnt != 0
  assign md_done  = !bus.md_busy && cnt != '0;
  assign br_taken = (bus.is_beq && bus.zero) || (bus.is_bne && !bus.zero);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= (state_n != state) ? '0 : (waiting && cnt != '1) ? cnt + 1'b1 : cnt;
      bus_err_q <= bus_err_q || state_n == TRAP;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = bus.imem_ack ? DECODE : mem_to ? TRAP : FETCH;
      DECODE:  state_n = (bus.is_jr || bus.is_j) ? FETCH : bus.is_jal ? WB : EXEC;
      EXEC:    state_n = (bus.is_beq || bus.is_bne) ? FETCH :
                         (bus.is_load || bus.is_store) ? MEM :
                         bus.is_muldiv ? MULDIV : bus.writes_reg ? WB : FETCH;
      MEM:     state_n = bus.dmem_ack ? (bus.is_load ? WB : FETCH) : mem_to ? TRAP : MEM;
      MULDIV:  state_n = md_done ? (bus.writes_reg ? WB : FETCH) : md_to ? TRAP : MULDIV;
      WB:      state_n = FETCH;
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
  end
  always_comb begin
    bus.imem_req   = on && state == FETCH;
    bus.ir_load    = on && state == FETCH && bus.imem_ack;
    bus.pc_load    = on && ((state == FETCH && bus.imem_ack) ||
                            (state == DECODE && (bus.is_jr || bus.is_j || bus.is_jal)) ||
                            (state == EXEC && (bus.is_beq || bus.is_bne) && br_taken));
    bus.pc_sel     = !on ? 2'b00 :
                     state == DECODE ? (bus.is_jr ? 2'b10 : (bus.is_j || bus.is_jal) ? 2'b11 : 2'b00) :
                     (state == EXEC && (bus.is_beq || bus.is_bne)) ? 2'b01 : 2'b00;
    bus.dmem_req   = on && state == MEM;
    bus.dmem_we    = on && state == MEM && bus.is_store;
    bus.mdr_load   = on && state == MEM && bus.dmem_ack && bus.is_load;
    bus.md_start   = on && state == MULDIV && cnt == '0;
    bus.regfile_we = on && state == WB;
    bus.retire     = on && state != FETCH && state_n == FETCH;
    bus.bus_err    = on && bus_err_q;
    bus.state_o    = on ? state : 3'd0;
  end
endmodule
